// File: rtl/seg7_scan_recoverer.sv
// Receive side of a scanned 7-segment bus: debounces each {seg,dig_sel} pattern,
// decodes it to a hex nibble in its slot and hands off complete words with valid/ready.
module seg7_scan_recoverer #(
   parameter int NDIG       = 8,
   parameter int STABLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        seg,
   input  logic [NDIG-1:0]   dig_sel,
   output logic [4*NDIG-1:0] word,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [NDIG-1:0]   filled,
   output logic              seg_err,
   output logic              digit_err,
   output logic              ovf
);

   localparam int SW = 7 + NDIG;
   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {TRACK, LOCKED} state_t;

   state_t          state;
   logic [SW-1:0]   samp;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nx;
   logic            same;
   logic            accept;
   logic            multi;
   logic [4:0]      dec;
   logic [IW-1:0]   idx;
   logic            hand;
   logic            store;
   logic [NDIG-1:0] filled_nx;

   // Returns {hit, nibble}; hit=0 for any pattern outside the hex font.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h7E: return 5'h10;  7'h30: return 5'h11;
         7'h6D: return 5'h12;  7'h79: return 5'h13;
         7'h33: return 5'h14;  7'h5B: return 5'h15;
         7'h5F: return 5'h16;  7'h70: return 5'h17;
         7'h7F: return 5'h18;  7'h7B: return 5'h19;
         7'h77: return 5'h1A;  7'h1F: return 5'h1B;
         7'h4E: return 5'h1C;  7'h3D: return 5'h1D;
         7'h4F: return 5'h1E;  7'h47: return 5'h1F;
         default: return 5'h00;
      endcase
   endfunction

   // NOTE: every variable in this block gets a default first so no latch is inferred.
   always_comb begin
      same   = ({seg, dig_sel} == samp);
      cnt_nx = CW'(1);
      if (same)
         cnt_nx = (cnt == CW'(STABLE_CYC)) ? cnt : cnt + CW'(1);
      accept = (state == TRACK) && (cnt_nx == CW'(STABLE_CYC)) && (|dig_sel);
      multi  = |(dig_sel & (dig_sel - NDIG'(1)));
      dec    = seg_decode(seg);
      idx    = '0;
      for (int i = 0; i < NDIG; i++)
         if (dig_sel[i]) idx = idx | IW'(i);
      hand      = word_valid & word_ready;
      store     = accept & ~multi & dec[4] & (~word_valid | word_ready);
      filled_nx = (hand ? '0 : filled) | (store ? dig_sel : '0);
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= TRACK;
         samp       <= '0;
         cnt        <= '0;
         word       <= '0;
         word_valid <= 1'b0;
         filled     <= '0;
         seg_err    <= 1'b0;
         digit_err  <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         samp <= {seg, dig_sel};
         cnt  <= cnt_nx;
         case (state)
            TRACK:  if (cnt_nx == CW'(STABLE_CYC)) state <= LOCKED;
            LOCKED: if (!same) state <= TRACK;
            default: state <= TRACK;
         endcase

         digit_err <= accept & multi;
         seg_err   <= accept & ~multi & ~dec[4];
         ovf       <= accept & ~multi & dec[4] & word_valid & ~word_ready;

         // Handoff is applied before the store, so a coincident capture starts a fresh word.
         filled     <= filled_nx;
         word_valid <= store ? (&filled_nx) : (word_valid & ~word_ready);
         if (store)
            word[4*idx +: 4] <= dec[3:0];
      end
   end

endmodule
